// File: rtl/cpu_pkg.sv
// Shared types for the multicycle control path.
// ALU op and state encodings, opcode constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLL = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SRL = 3'd4,
    ALU_OR  = 3'd5,
    ALU_AND = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } ctrl_state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_IALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_NOP
  } instr_class_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Plain funct3 mapping shared by R-type and I-ALU.
  function automatic alu_op_t funct3_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction classifier.
// Produces class, ALU op, operand-B select, illegal flag.
module ctrl_decoder
  import cpu_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t iclass,
  output alu_op_t      alu_op,
  output logic         alu_src_b,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Classify by opcode; only BEQ/BNE are legal branches.
  always_comb begin
    iclass    = C_NOP;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        iclass = C_RTYPE;
        if (funct3 == 3'b000 && instr[30])
          alu_op = ALU_SUB;
        else
          alu_op = funct3_op(funct3);
      end
      (opcode == OP_IALU): begin
        iclass    = C_IALU;
        alu_op    = funct3_op(funct3);
        alu_src_b = 1'b1;
      end
      (opcode == OP_LOAD): begin
        iclass    = C_LOAD;
        alu_src_b = 1'b1;
      end
      (opcode == OP_STORE): begin
        iclass    = C_STORE;
        alu_src_b = 1'b1;
      end
      (opcode == OP_BRANCH): begin
        iclass  = C_BRANCH;
        alu_op  = ALU_SUB;
        illegal = (funct3[2:1] != 2'b00);
      end
      (opcode == OP_JAL): begin
        iclass = C_JAL;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM, one instr in flight.
// ILLEGAL_TRAP_EN: illegal instr halts in TRAP until reset.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                alu_zero,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                pc_src,
  output logic                alu_src_b,
  output logic                result_src,
  output logic [2:0]          alu_op,
  output logic [2:0]          state,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  ctrl_state_t  st;
  ctrl_state_t  st_nx;
  logic [31:0]  ir;
  instr_class_t cls;
  alu_op_t      dec_op;
  logic         dec_srcb;
  logic         dec_ill;
  logic         br_taken;

  ctrl_decoder u_dec (
    .instr     (ir),
    .iclass    (cls),
    .alu_op    (dec_op),
    .alu_src_b (dec_srcb),
    .illegal   (dec_ill)
  );

  assign state     = st;
  assign alu_op    = dec_op;
  assign alu_src_b = dec_srcb;
  assign br_taken  = ir[12] ? ~alu_zero : alu_zero;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_FETCH;
    else       st <= st_nx;
  end

  // Instruction register, loaded on fetch completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ir <= '0;
    else if (ir_write) ir <= instruction;
  end

  // Retired counter, one per PC update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         retired <= '0;
    else if (pc_write) retired <= retired + RETIRE_W'(1);
  end

  // Next state and strobes.
  always_comb begin
    st_nx      = st;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 1'b0;
    result_src = 1'b0;
    trap       = 1'b0;
    unique case (st)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = ~reset;
          st_nx    = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        st_nx = dec_ill ? S_TRAP : S_EXEC;
`else
        st_nx = S_EXEC;
`endif
      end
      S_EXEC: begin
        if (dec_ill) begin
          pc_write = 1'b1;
          st_nx    = S_FETCH;
        end else if (cls == C_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = br_taken;
          st_nx    = S_FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          st_nx = S_MEM;
        end else begin
          st_nx = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_write = 1'b1;
            st_nx    = S_FETCH;
          end else begin
            st_nx = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = (ir[11:7] != 5'd0);
        pc_write   = 1'b1;
        pc_src     = (cls == C_JAL);
        result_src = (cls == C_LOAD);
        st_nx      = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        st_nx = S_FETCH;
`endif
      end
      default: begin
        st_nx = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed literal checks
// plus random stimulus against a queue-based phase model.
`timescale 1ns/1ps
module tb_multicycle_controller;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic        reg_write, pc_src, alu_src_b, result_src, trap;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .alu_zero(alu_zero), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .state(state), .trap(trap),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_ILL} kind_e;

  function automatic kind_e kind_of(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return (w[14:13] == 2'b00) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] exp_op(input logic [31:0] w);
    kind_e k = kind_of(w);
    if (k == K_BR) return 3'd1;
    if (k != K_R && k != K_I) return 3'd0;
    case (w[14:12])
      3'd0:    return (k == K_R && w[30]) ? 3'd1 : 3'd0;
      3'd1:    return 3'd2;
      3'd2:    return 3'd7;
      3'd3:    return 3'd7;
      3'd4:    return 3'd3;
      3'd5:    return 3'd4;
      3'd6:    return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  ctrl_state_t mph = S_FETCH;
  ctrl_state_t mq[$];
  logic [31:0] mw = '0;
  logic [31:0] mret = '0;
  kind_e       mk;
  logic ei, ed, ewe, eir, epw, erw, eps, ers, etr;

  function automatic ctrl_state_t pop_next();
    if (mq.size() != 0) return mq.pop_front();
    return S_FETCH;
  endfunction

  // Compare DUT against the model every cycle, then advance it.
  always @(negedge clk) begin
    {ei, ed, ewe, eir, epw, erw, eps, ers, etr} = '0;
    mk = kind_of(mw);
    if (reset) begin
      mph = S_FETCH;
      mq.delete();
      mret = '0;
      ei = 1'b1;
    end else begin
      case (mph)
        S_FETCH: begin
          ei  = 1'b1;
          eir = imem_ready;
        end
        S_EXEC: begin
          if (mk == K_BR) begin
            epw = 1'b1;
            eps = mw[12] ? !alu_zero : alu_zero;
          end else if (mk == K_ILL) begin
            epw = 1'b1;
          end
        end
        S_MEM: begin
          ed  = 1'b1;
          ewe = (mk == K_ST);
          epw = (mk == K_ST) && dmem_ready;
        end
        S_WB: begin
          erw = (mw[11:7] != 5'd0);
          epw = 1'b1;
          eps = (mk == K_JAL);
          ers = (mk == K_LD);
        end
        S_TRAP: etr = 1'b1;
        default: ;
      endcase
    end
    chk("state", 32'(state), 32'(mph));
    chk("imem_req", 32'(imem_req), 32'(ei));
    chk("dmem_req", 32'(dmem_req), 32'(ed));
    chk("dmem_we", 32'(dmem_we), 32'(ewe));
    chk("ir_write", 32'(ir_write), 32'(eir));
    chk("pc_write", 32'(pc_write), 32'(epw));
    chk("reg_write", 32'(reg_write), 32'(erw));
    chk("pc_src", 32'(pc_src), 32'(eps));
    chk("result_src", 32'(result_src), 32'(ers));
    chk("trap", 32'(trap), 32'(etr));
    chk("retired", retired, mret);
    if (!reset && mph != S_FETCH && mph != S_TRAP) begin
      chk("alu_src_b", 32'(alu_src_b),
          32'(mk == K_I || mk == K_LD || mk == K_ST));
      if (mk != K_ILL)
        chk("alu_op", 32'(alu_op), 32'(exp_op(mw)));
    end
    if (!reset) begin
      if (epw) mret = mret + 1;
      case (mph)
        S_FETCH: if (imem_ready) begin
          mw = instruction;
          mq.delete();
          mq.push_back(S_DECODE);
          case (kind_of(mw))
`ifdef ILLEGAL_TRAP_EN
            K_ILL: mq.push_back(S_TRAP);
`else
            K_ILL: mq.push_back(S_EXEC);
`endif
            K_BR: mq.push_back(S_EXEC);
            K_ST: begin mq.push_back(S_EXEC); mq.push_back(S_MEM); end
            K_LD: begin
              mq.push_back(S_EXEC);
              mq.push_back(S_MEM);
              mq.push_back(S_WB);
            end
            default: begin mq.push_back(S_EXEC); mq.push_back(S_WB); end
          endcase
          mph = pop_next();
        end
        S_MEM:  if (dmem_ready) mph = pop_next();
        S_TRAP: ;
        default: mph = pop_next();
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rst, input logic [31:0] ins,
                      input logic ir, input logic dr, input logic az);
    @(posedge clk);
    #1;
    reset = rst;
    instruction = ins;
    imem_ready = ir;
    dmem_ready = dr;
    alu_zero = az;
    #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin
        w[6:0] = 7'b0110011;
        w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      2: w[6:0] = 7'b0010011;
      3: w[6:0] = 7'b0000011;
      4: w[6:0] = 7'b0100011;
      5: begin
        w[6:0] = 7'b1100011;
        if ($urandom_range(0, 3) != 0) w[14:13] = 2'b00;
      end
      6: w[6:0] = 7'b1101111;
      7: w = 32'h0;
      8: ;
      default: w[6:0] = 7'b0110011;
    endcase
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  localparam logic [31:0] I_ADD  = 32'h005303b3;
  localparam logic [31:0] I_LW   = 32'h0000a283;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_BNE  = 32'h00001463;
  localparam logic [31:0] I_ADDI = 32'h00100013;
  localparam logic [31:0] I_SW   = 32'h0050a023;

  int n;

  initial begin
    repeat (3) @(posedge clk);
    step(1'b1, I_ADD, 1'b1, 1'b0, 1'b0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    // add x7,x6,x5
    step(1'b0, I_ADD, 1'b1, 1'b0, 1'b0);
    chk("rel_imem_req", 32'(imem_req), 32'd1);
    chk("add_ir_write", 32'(ir_write), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("add_decode", 32'(state), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("add_exec", 32'(state), 32'd2);
    chk("add_alu_op", 32'(alu_op), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("add_wb", 32'(state), 32'd4);
    chk("add_reg_write", 32'(reg_write), 32'd1);
    chk("add_pc_write", 32'(pc_write), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("add_retired", retired, 32'd1);
    // lw with 3 wait cycles
    step(1'b0, I_LW, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lw_src_b", 32'(alu_src_b), 32'd1);
    n = 0;
    repeat (3) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n += int'(dmem_req);
      chk("lw_we", 32'(dmem_we), 32'd0);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    n += int'(dmem_req);
    chk("lw_req_cycles", 32'(n), 32'd4);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lw_wb", 32'(state), 32'd4);
    chk("lw_result_src", 32'(result_src), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lw_retired", retired, 32'd2);
    // beq taken
    step(1'b0, I_BEQ, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("beq_pc_write", 32'(pc_write), 32'd1);
    chk("beq_pc_src", 32'(pc_src), 32'd1);
    chk("beq_reg_write", 32'(reg_write), 32'd0);
    chk("beq_alu_op", 32'(alu_op), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("beq_retired", retired, 32'd3);
    // bne not taken
    step(1'b0, I_BNE, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bne_pc_write", 32'(pc_write), 32'd1);
    chk("bne_pc_src", 32'(pc_src), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("bne_retired", retired, 32'd4);
    // all-zero word is illegal
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    n = 0;
    repeat (20) begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      n += int'(trap && !imem_req && state == 3'd5);
    end
    chk("ill_trap_cycles", 32'(n), 32'd20);
    chk("ill_retired", retired, 32'd4);
`else
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ill_exec", 32'(state), 32'd2);
    chk("ill_pc_write", 32'(pc_write), 32'd1);
    chk("ill_pc_src", 32'(pc_src), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("ill_fetch", 32'(state), 32'd0);
    chk("ill_retired", retired, 32'd5);
`endif
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("rst2_retired", retired, 32'd0);
    // addi x0,x0,1
    step(1'b0, I_ADDI, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("addi_rd0_reg_write", 32'(reg_write), 32'd0);
    chk("addi_pc_write", 32'(pc_write), 32'd1);
    // sw interrupted by reset in MEM
    step(1'b0, I_SW, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("sw_dmem_req", 32'(dmem_req), 32'd1);
    chk("sw_dmem_we", 32'(dmem_we), 32'd1);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("sw_rst_req", 32'(dmem_req), 32'd0);
    chk("sw_rst_state", 32'(state), 32'd0);
    chk("sw_rst_retired", retired, 32'd0);
    // random traffic, model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 59) == 0), rnd_instr(),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) != 0),
           ($urandom_range(0, 1) != 0));
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #6;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: RETIRE_W, 32, width of retired-instruction counter.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: instruction  input  32  instruction word from instruction memory, valid when imem_ready=1.
REQ-005 Port: imem_ready  input  1  instruction fetch complete.
REQ-006 Port: dmem_ready  input  1  data access complete.
REQ-007 Port: alu_zero  input  1  ALU result equals zero.
REQ-008 Port: imem_req, dmem_req, dmem_we  output  1 each  memory request strobes, dmem_we valid with dmem_req.
REQ-009 Port: ir_write, pc_write, reg_write  output  1 each  latch IR, update PC, write rd.
REQ-010 Port: pc_src  output  1  0 = pc+4, 1 = branch/JAL target.
REQ-011 Port: alu_src_b  output  1  0 = rs2, 1 = sign-extended immediate.
REQ-012 Port: result_src  output  1  0 = ALU result, 1 = load data.
REQ-013 Port: alu_op  output  3  ALU operation, encoding ADD..SLT = 0..7.
REQ-014 Port: state  output  3  current FSM state.  trap  output  1  illegal-instruction halt.
REQ-015 Port: retired  output  RETIRE_W  retired-instruction count.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; one instruction in flight, no overlap.
REQ-017 FETCH: imem_req=1 every cycle; on imem_ready: ir_write=1, next DECODE; else hold.
REQ-018 DECODE: one cycle; illegal opcode/funct -> illegal handling (REQ-030/031); otherwise EXEC.
REQ-019 EXEC: R-type/I-ALU/JAL -> WB; LOAD/STORE -> MEM; BRANCH -> FETCH with pc_write=1, pc_src=taken.
REQ-020 Branch taken: BEQ (funct3 000) if alu_zero=1; BNE (001) if alu_zero=0; other funct3 illegal.
REQ-021 MEM: dmem_req=1, dmem_we=1 for STORE; hold until dmem_ready; LOAD -> WB; STORE -> FETCH with pc_write=1, pc_src=0.
REQ-022 WB: reg_write=1 unless rd=0; pc_write=1; pc_src=1 for JAL else 0; result_src=1 only for LOAD; next FETCH.
REQ-023 alu_op: funct3 000 ADD (SUB if R-type and funct7[5]); 001 SLL; 010/011 SLT; 100 XOR; 101 SRL; 110 OR; 111 AND; LOAD/STORE/JAL ADD; BRANCH SUB.
REQ-024 alu_src_b=1 for I-ALU, LOAD, STORE; 0 otherwise.
REQ-025 Every strobe output (req, write, trap) SHALL be Moore-decoded, one cycle wide except held requests.
REQ-026 retired SHALL increment by 1 in the cycle pc_write=1, wrapping modulo 2^RETIRE_W.
REQ-027 Recognised opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111; all others illegal.

Reset
REQ-028 reset=1 SHALL immediately force state=FETCH, retired=0, trap=0, all strobes 0 except imem_req; mid-access requests SHALL be dropped without completion.
REQ-029 First imem_req SHALL assert in the cycle reset deasserts.

Configuration
REQ-030 With ILLEGAL_TRAP_EN defined: illegal instruction -> TRAP; trap=1, all other strobes 0, retired frozen, exit only by reset.
REQ-031 Without ILLEGAL_TRAP_EN: illegal instruction -> EXEC as NOP, then FETCH with pc_write=1, pc_src=0, retired incremented; TRAP unreachable, trap tied 0.

Structure
REQ-032 Shared package cpu_pkg SHALL hold alu_op_t, ctrl_state_t and opcode localparams.
REQ-033 Sub-module ctrl_decoder SHALL combinationally produce instruction class, alu_op, alu_src_b, illegal.

Verification
REQ-034 0x005303b3 (add x7,x6,x5), imem_ready=1 -> FETCH,DECODE,EXEC,WB; alu_op=ADD; reg_write=1 and pc_write=1 in cycle 4; retired=1.
REQ-035 lw, dmem_ready low 3 cycles in MEM -> dmem_req held 4 cycles, dmem_we=0, then WB with result_src=1.
REQ-036 beq, alu_zero=1 -> EXEC pc_write=1, pc_src=1, no reg_write; bne, alu_zero=1 -> pc_src=0.
REQ-037 Instruction 0x00000000: with ILLEGAL_TRAP_EN -> TRAP, trap=1 held 20 cycles, retired unchanged; without -> retired+1, back to FETCH.
REQ-038 addi with rd=0 -> no reg_write; reset asserted during MEM sw -> dmem_req drops same cycle, state=FETCH, retired=0.
